// File: rtl/rs_alu_pkg.sv
// ---------------------------------------------------------------------------
// rs_alu_pkg
// Shared types, sizes and helpers for the ALU reservation station.
//   - RS_SIZE / RS_ID_W : entry count and entry index width
//   - ROB_POS_W         : reorder-buffer index width (dependency tags)
//   - operand_t         : one source operand (value or pending ROB tag)
//   - cdb_t             : one result broadcast (ALU or LSB)
//   - rs_entry_t        : one reservation-station slot
//   - alu_req_t         : the registered dispatch bundle sent to the ALU
// ---------------------------------------------------------------------------
package rs_alu_pkg;

    localparam int RS_SIZE   = 16;
    localparam int RS_ID_W   = 4;
    localparam int ROB_POS_W = 4;
    localparam int OPCODE_W  = 7;
    localparam int FUNC3_W   = 3;
    localparam int DATA_W    = 32;

    typedef logic [RS_ID_W-1:0]   rs_id_t;
    typedef logic [ROB_POS_W-1:0] rob_pos_t;
    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [OPCODE_W-1:0]  opcode_t;
    typedef logic [FUNC3_W-1:0]   func3_t;

    // A source operand: when has_dep is set, val is stale and dep names the
    // ROB slot whose result is still outstanding.
    typedef struct packed {
        logic     has_dep;
        rob_pos_t dep;
        data_t    val;
    } operand_t;

    // A result broadcast as seen on the ALU or LSB bus.
    typedef struct packed {
        logic     valid;
        rob_pos_t rob_pos;
        data_t    val;
    } cdb_t;

    typedef struct packed {
        logic     busy;
        opcode_t  opcode;
        func3_t   func3;
        logic     func1;
        operand_t op1;
        operand_t op2;
        data_t    imm;
        data_t    pc;
        rob_pos_t rob_pos;
    } rs_entry_t;

    typedef struct packed {
        logic     en;
        opcode_t  opcode;
        func3_t   func3;
        logic     func1;
        data_t    val1;
        data_t    val2;
        data_t    imm;
        data_t    pc;
        rob_pos_t rob_pos;
    } alu_req_t;

    // Capture a broadcast into a waiting operand. The two buses never carry
    // the same tag in one cycle, so the check order has no architectural
    // meaning.
    function automatic operand_t snoop_operand(input operand_t op,
                                               input cdb_t     alu_cdb,
                                               input cdb_t     lsb_cdb);
        operand_t res;
        res = op;
        if (op.has_dep) begin
            if (alu_cdb.valid && (alu_cdb.rob_pos == op.dep)) begin
                res.has_dep = 1'b0;
                res.val     = alu_cdb.val;
            end else if (lsb_cdb.valid && (lsb_cdb.rob_pos == op.dep)) begin
                res.has_dep = 1'b0;
                res.val     = lsb_cdb.val;
            end
        end
        return res;
    endfunction

    // An entry may go to the ALU once it holds both operand values.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.busy && !e.op1.has_dep && !e.op2.has_dep;
    endfunction

    function automatic alu_req_t to_alu_req(input rs_entry_t e);
        alu_req_t r;
        r.en      = 1'b1;
        r.opcode  = e.opcode;
        r.func3   = e.func3;
        r.func1   = e.func1;
        r.val1    = e.op1.val;
        r.val2    = e.op2.val;
        r.imm     = e.imm;
        r.pc      = e.pc;
        r.rob_pos = e.rob_pos;
        return r;
    endfunction

endpackage

// File: rtl/rs_prio_enc.sv
// ---------------------------------------------------------------------------
// rs_prio_enc
// Lowest-index priority encoder.
//   vec  : request vector, bit 0 has the highest priority
//   idx  : index of the lowest set bit (0 when nothing is set)
//   any  : at least one bit of vec is set
// ---------------------------------------------------------------------------
module rs_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scanning from the top down lets the lowest set bit write last and win.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves it unassigned, which would infer a latch.
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/rs_alu.sv
// ---------------------------------------------------------------------------
// rs_alu
// Reservation station in front of the integer/branch/jump ALU. Holds issued
// micro-ops until both operands are known, snoops the ALU and LSB result
// buses for missing operands, and hands at most one ready entry per cycle
// to the ALU through a registered output bundle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   rdy                 : global enable; low freezes all state and outputs
//   rollback            : mispredict flush of every entry and the output
//   issue_*             : new micro-op from dispatch (issue_en qualifies)
//   full                : every entry busy (from registered state only)
//   alu_*  (outputs)    : registered dispatch to the ALU (alu_en qualifies)
//   alu_result*         : ALU result broadcast (valid, tag, value)
//   lsb_result*         : LSB result broadcast (valid, tag, value)
// ---------------------------------------------------------------------------
module rs_alu
    import rs_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,

    input  logic                 issue_en,
    input  logic [OPCODE_W-1:0]  issue_opcode,
    input  logic [FUNC3_W-1:0]   issue_func3,
    input  logic                 issue_func1,
    input  logic                 issue_has_dep1,
    input  logic [ROB_POS_W-1:0] issue_dep1,
    input  logic [DATA_W-1:0]    issue_val1,
    input  logic                 issue_has_dep2,
    input  logic [ROB_POS_W-1:0] issue_dep2,
    input  logic [DATA_W-1:0]    issue_val2,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [DATA_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,

    output logic                 full,

    output logic                 alu_en,
    output logic [OPCODE_W-1:0]  alu_opcode,
    output logic [FUNC3_W-1:0]   alu_func3,
    output logic                 alu_func1,
    output logic [DATA_W-1:0]    alu_val1,
    output logic [DATA_W-1:0]    alu_val2,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [DATA_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos,

    input  logic                 alu_result,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_result,
    input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_result_val
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];
    alu_req_t  alu_req_q;
    alu_req_t  alu_req_d;

    // -----------------------------------------------------------------------
    // Broadcast buses and the incoming entry
    // -----------------------------------------------------------------------
    cdb_t      alu_cdb;
    cdb_t      lsb_cdb;
    rs_entry_t issue_entry;

    assign alu_cdb = '{valid: alu_result, rob_pos: alu_result_rob_pos, val: alu_result_val};
    assign lsb_cdb = '{valid: lsb_result, rob_pos: lsb_result_rob_pos, val: lsb_result_val};

    // Operands are bypassed from this cycle's broadcasts before the entry is
    // written, so a producer finishing in the issue cycle is never missed.
    // Operands issued without a dependency (LUI/AUIPC/JAL) pass through as
    // given because snooping only touches operands that are still waiting.
    always_comb begin
        operand_t op1_raw;
        operand_t op2_raw;
        op1_raw = '{has_dep: issue_has_dep1, dep: issue_dep1, val: issue_val1};
        op2_raw = '{has_dep: issue_has_dep2, dep: issue_dep2, val: issue_val2};

        issue_entry         = '0;
        issue_entry.busy    = 1'b1;
        issue_entry.opcode  = issue_opcode;
        issue_entry.func3   = issue_func3;
        issue_entry.func1   = issue_func1;
        issue_entry.op1     = snoop_operand(op1_raw, alu_cdb, lsb_cdb);
        issue_entry.op2     = snoop_operand(op2_raw, alu_cdb, lsb_cdb);
        issue_entry.imm     = issue_imm;
        issue_entry.pc      = issue_pc;
        issue_entry.rob_pos = issue_rob_pos;
    end

    // -----------------------------------------------------------------------
    // Free-slot and ready-slot selection from registered state
    // -----------------------------------------------------------------------
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    rs_id_t             free_idx;
    rs_id_t             ready_idx;
    logic               free_any;
    logic               ready_any;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !entries_q[i].busy;
            ready_vec[i] = entry_ready(entries_q[i]);
        end
    end

    rs_prio_enc #(
        .WIDTH (RS_SIZE),
        .IDX_W (RS_ID_W)
    ) u_free_enc (
        .vec (free_vec),
        .idx (free_idx),
        .any (free_any)
    );

    rs_prio_enc #(
        .WIDTH (RS_SIZE),
        .IDX_W (RS_ID_W)
    ) u_ready_enc (
        .vec (ready_vec),
        .idx (ready_idx),
        .any (ready_any)
    );

    assign full = !free_any;

    // -----------------------------------------------------------------------
    // Next state: wakeup, dispatch, issue; rollback overrides all three.
    // -----------------------------------------------------------------------
    always_comb begin
        entries_d    = entries_q;
        alu_req_d    = alu_req_q;
        alu_req_d.en = 1'b0;

        if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_d[i].busy = 1'b0;
            end
            alu_req_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (entries_q[i].busy) begin
                    entries_d[i].op1 = snoop_operand(entries_q[i].op1, alu_cdb, lsb_cdb);
                    entries_d[i].op2 = snoop_operand(entries_q[i].op2, alu_cdb, lsb_cdb);
                end
            end

            // Only operands already complete before this edge may dispatch,
            // which keeps wakeup and issue off the ALU-facing timing path.
            if (ready_any) begin
                alu_req_d                = to_alu_req(entries_q[ready_idx]);
                entries_d[ready_idx].busy = 1'b0;
            end

            // free_idx comes from pre-edge state, so it can never collide with
            // the slot being dispatched (that one was still busy).
            if (issue_en && free_any) begin
                entries_d[free_idx] = issue_entry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the busy bits are reset; payload fields of a free
            // entry are never read, so clearing them would be wasted logic.
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i].busy <= 1'b0;
            end
            alu_req_q <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of every other flop, independent of code order.
            entries_q <= entries_d;
            alu_req_q <= alu_req_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign alu_en      = alu_req_q.en;
    assign alu_opcode  = alu_req_q.opcode;
    assign alu_func3   = alu_req_q.func3;
    assign alu_func1   = alu_req_q.func1;
    assign alu_val1    = alu_req_q.val1;
    assign alu_val2    = alu_req_q.val2;
    assign alu_imm     = alu_req_q.imm;
    assign alu_pc      = alu_req_q.pc;
    assign alu_rob_pos = alu_req_q.rob_pos;

endmodule

// File: tb/tb_rs_alu.sv
// ---------------------------------------------------------------------------
// tb_rs_alu
// Self-checking bench for rs_alu. Every expected dispatch is pushed to a
// scoreboard queue together with the clock edge it must appear after; a
// monitor pops and compares whenever alu_en is seen high.
// ---------------------------------------------------------------------------
module tb_rs_alu;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic        issue_func1;
    logic        issue_has_dep1;
    logic [3:0]  issue_dep1;
    logic [31:0] issue_val1;
    logic        issue_has_dep2;
    logic [3:0]  issue_dep2;
    logic [31:0] issue_val2;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_pos;
    logic        full;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func1;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        lsb_result;
    logic [3:0]  lsb_result_rob_pos;
    logic [31:0] lsb_result_val;

    rs_alu dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .rollback           (rollback),
        .issue_en           (issue_en),
        .issue_opcode       (issue_opcode),
        .issue_func3        (issue_func3),
        .issue_func1        (issue_func1),
        .issue_has_dep1     (issue_has_dep1),
        .issue_dep1         (issue_dep1),
        .issue_val1         (issue_val1),
        .issue_has_dep2     (issue_has_dep2),
        .issue_dep2         (issue_dep2),
        .issue_val2         (issue_val2),
        .issue_imm          (issue_imm),
        .issue_pc           (issue_pc),
        .issue_rob_pos      (issue_rob_pos),
        .full               (full),
        .alu_en             (alu_en),
        .alu_opcode         (alu_opcode),
        .alu_func3          (alu_func3),
        .alu_func1          (alu_func1),
        .alu_val1           (alu_val1),
        .alu_val2           (alu_val2),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_rob_pos        (alu_rob_pos),
        .alu_result         (alu_result),
        .alu_result_rob_pos (alu_result_rob_pos),
        .alu_result_val     (alu_result_val),
        .lsb_result         (lsb_result),
        .lsb_result_rob_pos (lsb_result_rob_pos),
        .lsb_result_val     (lsb_result_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    logic rdy_s  = 1'b0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rdy_s    <= rdy;
    end

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic        func1;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        int          edge_no;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic        hd1;
        logic [3:0]  d1;
        logic [31:0] v1;
        logic        hd2;
        logic [3:0]  d2;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic        av;
        logic [3:0]  at;
        logic [31:0] aval;
        logic        lv;
        logic [3:0]  lt;
        logic [31:0] lval;
        logic [31:0] ev1;
        logic [31:0] ev2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Upstream must never issue into a full station.
    always @(posedge clk) begin
        if (!rst && rdy && issue_en && full) begin
            n_fail++;
            $display("FAIL issue_while_full: issue_en=1 with full=1 at edge %0d", edge_cnt);
        end
    end

    // -----------------------------------------------------------------------
    // Monitor: every dispatch must match the head of the scoreboard.
    // -----------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_s && alu_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_dispatch: alu_en=1 rob_pos=%0d, expected no dispatch (edge %0d)",
                             alu_rob_pos, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("disp_edge",   32'(edge_cnt),    32'(e.edge_no));
                    check("disp_rob",    32'(alu_rob_pos), 32'(e.rob));
                    check("disp_opcode", 32'(alu_opcode),  32'(e.opcode));
                    check("disp_func3",  32'(alu_func3),   32'(e.func3));
                    check("disp_func1",  32'(alu_func1),   32'(e.func1));
                    check("disp_val1",   alu_val1,         e.val1);
                    check("disp_val2",   alu_val2,         e.val2);
                    check("disp_imm",    alu_imm,          e.imm);
                    check("disp_pc",     alu_pc,           e.pc);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_en       = 1'b0;
        issue_opcode   = '0;
        issue_func3    = '0;
        issue_func1    = 1'b0;
        issue_has_dep1 = 1'b0;
        issue_dep1     = '0;
        issue_val1     = '0;
        issue_has_dep2 = 1'b0;
        issue_dep2     = '0;
        issue_val2     = '0;
        issue_imm      = '0;
        issue_pc       = '0;
        issue_rob_pos  = '0;
        alu_result     = 1'b0;
        alu_result_rob_pos = '0;
        alu_result_val = '0;
        lsb_result     = 1'b0;
        lsb_result_rob_pos = '0;
        lsb_result_val = '0;
        rollback       = 1'b0;
    endtask

    task automatic drive_issue(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                               input logic hd1, input logic [3:0] d1, input logic [31:0] v1,
                               input logic hd2, input logic [3:0] d2, input logic [31:0] v2,
                               input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
        issue_en       = 1'b1;
        issue_opcode   = opc;
        issue_func3    = f3;
        issue_func1    = f1;
        issue_has_dep1 = hd1;
        issue_dep1     = d1;
        issue_val1     = v1;
        issue_has_dep2 = hd2;
        issue_dep2     = d2;
        issue_val2     = v2;
        issue_imm      = imm;
        issue_pc       = pc;
        issue_rob_pos  = rob;
    endtask

    task automatic drive_alu(input logic [3:0] tag, input logic [31:0] val);
        alu_result         = 1'b1;
        alu_result_rob_pos = tag;
        alu_result_val     = val;
    endtask

    task automatic drive_lsb(input logic [3:0] tag, input logic [31:0] val);
        lsb_result         = 1'b1;
        lsb_result_rob_pos = tag;
        lsb_result_val     = val;
    endtask

    task automatic push_exp(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [3:0] rob, input int edge_no);
        exp_t e;
        e.opcode = opc; e.func3 = f3; e.func1 = f1;
        e.val1 = v1; e.val2 = v2; e.imm = imm; e.pc = pc; e.rob = rob;
        e.edge_no = edge_no;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            tick();
        end
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic vec_t mk_vec(
        input logic [6:0] opc, input logic [2:0] f3, input logic f1,
        input logic hd1, input logic [3:0] d1, input logic [31:0] v1,
        input logic hd2, input logic [3:0] d2, input logic [31:0] v2,
        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob,
        input logic av, input logic [3:0] at, input logic [31:0] aval,
        input logic lv, input logic [3:0] lt, input logic [31:0] lval,
        input logic [31:0] ev1, input logic [31:0] ev2);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f1 = f1;
        v.hd1 = hd1; v.d1 = d1; v.v1 = v1;
        v.hd2 = hd2; v.d2 = d2; v.v2 = v2;
        v.imm = imm; v.pc = pc; v.rob = rob;
        v.av = av; v.at = at; v.aval = aval;
        v.lv = lv; v.lt = lt; v.lval = lval;
        v.ev1 = ev1; v.ev2 = ev2;
        return v;
    endfunction

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        vec_t vecs[7];

        // Ready-at-issue vectors (no deps, or deps satisfied by a same-cycle
        // broadcast). Each dispatches two edges after it is driven.
        vecs[0] = mk_vec(OP_IMM, 3'b000, 1'b0, 1'b0, 4'd0, 32'd5,   1'b0, 4'd0, 32'd0,
                         32'd7, 32'h100, 4'd3,
                         1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd0);
        vecs[1] = mk_vec(OP_REG, 3'b000, 1'b1, 1'b0, 4'd0, 32'd100, 1'b0, 4'd0, 32'd30,
                         32'd0, 32'h104, 4'd5,
                         1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd100, 32'd30);
        vecs[2] = mk_vec(OP_REG, 3'b111, 1'b0, 1'b0, 4'd0, 32'h0F0F, 1'b1, 4'd6, 32'hDEAD,
                         32'd0, 32'h108, 4'd7,
                         1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hFF, 32'h0F0F, 32'hFF);
        vecs[3] = mk_vec(OP_BR,  3'b000, 1'b0, 1'b1, 4'd9, 32'h1234, 1'b0, 4'd0, 32'hCAFE,
                         32'hFFFF_FFF8, 32'h10C, 4'd8,
                         1'b1, 4'd9, 32'hCAFE, 1'b0, 4'd0, 32'd0, 32'hCAFE, 32'hCAFE);
        vecs[4] = mk_vec(OP_REG, 3'b010, 1'b0, 1'b1, 4'd11, 32'd0, 1'b1, 4'd10, 32'd0,
                         32'd0, 32'h110, 4'd9,
                         1'b1, 4'd10, 32'hA, 1'b1, 4'd11, 32'hB, 32'hB, 32'hA);
        vecs[5] = mk_vec(OP_LUI, 3'b000, 1'b0, 1'b0, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0,
                         32'h1234_5000, 32'h114, 4'd10,
                         1'b1, 4'd12, 32'h99999, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
        vecs[6] = mk_vec(OP_JAL, 3'b000, 1'b0, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0,
                         32'h40, 32'h118, 4'd11,
                         1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h55, 32'h77, 32'd0);

        clear_inputs();
        rdy = 1'b1;
        rst = 1'b1;

        // ---- Reset state ----
        repeat (3) tick();
        check("rst_full",    32'(full),        32'd0);
        check("rst_alu_en",  32'(alu_en),      32'd0);
        check("rst_alu_val1", alu_val1,        32'd0);
        check("rst_alu_rob", 32'(alu_rob_pos), 32'd0);
        rst = 1'b0;

        // Three entries waiting on tag 5, then reset wipes them.
        for (int i = 0; i < 3; i++) begin
            drive_issue(OP_REG, 3'b000, 1'b0, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd1,
                        32'd0, 32'h80 + 32'(i * 4), 4'(i));
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_full",   32'(full),   32'd0);
        check("rst2_alu_en", 32'(alu_en), 32'd0);
        drive_alu(4'd5, 32'h55);
        tick();
        clear_inputs();
        repeat (4) tick();

        // ---- Table-driven ready issues, one per cycle ----
        for (int i = 0; i < 7; i++) begin
            drive_issue(vecs[i].opc, vecs[i].f3, vecs[i].f1,
                        vecs[i].hd1, vecs[i].d1, vecs[i].v1,
                        vecs[i].hd2, vecs[i].d2, vecs[i].v2,
                        vecs[i].imm, vecs[i].pc, vecs[i].rob);
            if (vecs[i].av) drive_alu(vecs[i].at, vecs[i].aval);
            if (vecs[i].lv) drive_lsb(vecs[i].lt, vecs[i].lval);
            push_exp(vecs[i].opc, vecs[i].f3, vecs[i].f1, vecs[i].ev1, vecs[i].ev2,
                     vecs[i].imm, vecs[i].pc, vecs[i].rob, edge_cnt + 2);
            tick();
            clear_inputs();
        end
        wait_drain(10);
        tick();
        // Outputs hold the last dispatch while idle.
        check("hold_alu_en",  32'(alu_en),      32'd0);
        check("hold_alu_imm", alu_imm,          32'h40);
        check("hold_alu_rob", 32'(alu_rob_pos), 32'd11);

        // ---- Wakeup from ALU broadcast ----
        drive_issue(OP_REG, 3'b000, 1'b0, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd10,
                    32'd0, 32'h300, 4'd4);
        tick();
        clear_inputs();
        repeat (2) tick();
        drive_alu(4'd2, 32'h20);
        push_exp(OP_REG, 3'b000, 1'b0, 32'h20, 32'd10, 32'd0, 32'h300, 4'd4, edge_cnt + 2);
        tick();
        clear_inputs();
        wait_drain(10);

        // ---- Two deps woken in different cycles ----
        drive_issue(OP_REG, 3'b110, 1'b0, 1'b1, 4'd7, 32'd0, 1'b1, 4'd8, 32'd0,
                    32'd0, 32'h304, 4'd6);
        tick();
        clear_inputs();
        drive_alu(4'd7, 32'h70);
        tick();
        clear_inputs();
        repeat (2) tick();
        drive_lsb(4'd8, 32'h80);
        push_exp(OP_REG, 3'b110, 1'b0, 32'h70, 32'h80, 32'd0, 32'h304, 4'd6, edge_cnt + 2);
        tick();
        clear_inputs();
        wait_drain(10);

        // ---- Both broadcasts in one cycle ----
        drive_issue(OP_REG, 3'b100, 1'b0, 1'b1, 4'd3, 32'd0, 1'b1, 4'd4, 32'd0,
                    32'd0, 32'h308, 4'd12);
        tick();
        clear_inputs();
        drive_alu(4'd3, 32'h333);
        drive_lsb(4'd4, 32'h444);
        push_exp(OP_REG, 3'b100, 1'b0, 32'h333, 32'h444, 32'd0, 32'h308, 4'd12, edge_cnt + 2);
        tick();
        clear_inputs();
        wait_drain(10);

        // ---- rdy freeze: nothing moves, junk issue ignored ----
        drive_issue(OP_IMM, 3'b001, 1'b0, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'd0,
                    32'd3, 32'h400, 4'd13);
        push_exp(OP_IMM, 3'b001, 1'b0, 32'h9, 32'd0, 32'd3, 32'h400, 4'd13, edge_cnt + 5);
        tick();
        rdy = 1'b0;
        drive_issue(OP_IMM, 3'b000, 1'b0, 1'b0, 4'd0, 32'hBAD, 1'b0, 4'd0, 32'd0,
                    32'd0, 32'h404, 4'd14);
        repeat (3) tick();
        check("freeze_alu_en", 32'(alu_en), 32'd0);
        clear_inputs();
        rdy = 1'b1;
        wait_drain(10);

        // ---- Fill all 16 entries on tag 1, then release in index order ----
        for (int i = 0; i < 16; i++) begin
            drive_issue(OP_REG, 3'b000, 1'b0, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i),
                        32'(i * 4), 32'h200 + 32'(i * 4), 4'(i));
            tick();
            if (i == 14) check("fill15_full", 32'(full), 32'd0);
        end
        clear_inputs();
        check("fill16_full", 32'(full), 32'd1);
        drive_alu(4'd1, 32'h1000);
        for (int i = 0; i < 16; i++) begin
            push_exp(OP_REG, 3'b000, 1'b0, 32'h1000, 32'(i), 32'(i * 4),
                     32'h200 + 32'(i * 4), 4'(i), edge_cnt + 2 + i);
        end
        tick();
        clear_inputs();
        check("woken_full", 32'(full), 32'd1);
        tick();
        check("first_disp_full", 32'(full), 32'd0);
        wait_drain(30);

        // ---- Rollback with four ready entries pending ----
        for (int i = 0; i < 4; i++) begin
            drive_issue(OP_REG, 3'b000, 1'b0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd2,
                        32'd0, 32'h500 + 32'(i * 4), 4'(i + 4));
            tick();
        end
        clear_inputs();
        drive_alu(4'd9, 32'h900);
        tick();
        clear_inputs();
        rollback = 1'b1;
        drive_issue(OP_IMM, 3'b000, 1'b0, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'd0,
                    32'd0, 32'h600, 4'd15);
        tick();
        clear_inputs();
        check("rb_alu_en",   32'(alu_en),      32'd0);
        check("rb_alu_rob",  32'(alu_rob_pos), 32'd0);
        check("rb_alu_val1", alu_val1,         32'd0);
        check("rb_full",     32'(full),        32'd0);
        repeat (4) tick();
        drive_issue(OP_IMM, 3'b000, 1'b0, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'd0,
                    32'd2, 32'h700, 4'd14);
        push_exp(OP_IMM, 3'b000, 1'b0, 32'h21, 32'd0, 32'd2, 32'h700, 4'd14, edge_cnt + 2);
        tick();
        clear_inputs();
        wait_drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
